// File: rtl/red_unit.sv
// red_unit: multi-cycle lane-sum reduction. Both operands are split into
// LANES lanes of LANE_W bits. One lane pair is accumulated per cycle, and the
// extended sum is returned through a valid/ready handshake.
module red_unit #(
  parameter int DATA_W = 16,
  parameter int LANE_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] In1,
  input  logic [DATA_W-1:0] In2,
  input  logic              signed_lanes,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] Sum,
  output logic              busy
);

  localparam int LANES = DATA_W / LANE_W;
  localparam int IDX_W = $clog2(LANES);
  // Headroom: one bit for the pair add, clog2(LANES) bits for the lane sum.
  localparam int RES_W = LANE_W + 1 + IDX_W;

  if (DATA_W % LANE_W != 0) begin : g_chk_div
    $error("red_unit: DATA_W must be a multiple of LANE_W");
  end
  if (LANES < 2 || (LANES & (LANES - 1)) != 0) begin : g_chk_pow2
    $error("red_unit: LANES must be a power of two and at least 2");
  end
  if (DATA_W < RES_W) begin : g_chk_res
    $error("red_unit: DATA_W must be at least RES_W");
  end

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  op1_q, op1_d;
  logic [DATA_W-1:0]  op2_q, op2_d;
  logic               sgn_q, sgn_d;
  logic [RES_W-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  sum_q, sum_d;

  logic [LANE_W-1:0]  lane1, lane2;
  logic [RES_W-1:0]   acc_nxt;
  logic [DATA_W-1:0]  sum_ext;
  logic               last_lane;

  // Widen one lane to the accumulator width, copying its sign bit only in signed mode.
  function automatic logic [RES_W-1:0] ext_lane(input logic [LANE_W-1:0] lane,
                                                input logic sgn);
    return {{(RES_W - LANE_W){sgn & lane[LANE_W-1]}}, lane};
  endfunction

  // State register; an asynchronous reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: accept, one lane per cycle, then hold until the result is taken.
  always_comb begin
    // NOTE: a default assignment first keeps every path assigned, so no latch is inferred.
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid)  state_d = S_ACC;
      S_ACC:   if (last_lane) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // Handshake and status outputs are decoded from the state alone.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
    Sum       = sum_q;
  end

  // Current lane pair, running sum and the extended result used at completion.
  always_comb begin
    lane1     = op1_q[int'(idx_q) * LANE_W +: LANE_W];
    lane2     = op2_q[int'(idx_q) * LANE_W +: LANE_W];
    acc_nxt   = acc_q + ext_lane(lane1, sgn_q) + ext_lane(lane2, sgn_q);
    last_lane = (idx_q == IDX_W'(LANES - 1));
    // Fill with the sign bit (or zero), then overlay the accumulator; also valid when DATA_W == RES_W.
    sum_ext          = {DATA_W{sgn_q & acc_nxt[RES_W-1]}};
    sum_ext[RES_W-1:0] = acc_nxt;
  end

  // Datapath next state: capture at accept, accumulate in ACC, load Sum on the last lane.
  always_comb begin
    op1_d = op1_q;
    op2_d = op2_q;
    sgn_d = sgn_q;
    acc_d = acc_q;
    idx_d = idx_q;
    sum_d = sum_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op1_d = In1;
          op2_d = In2;
          sgn_d = signed_lanes;
          acc_d = '0;
          idx_d = '0;
        end
      end
      S_ACC: begin
        acc_d = acc_nxt;
        idx_d = idx_q + IDX_W'(1);  // wraps to 0 on the last lane
        if (last_lane) sum_d = sum_ext;
      end
      default: ;
    endcase
  end

  // Datapath registers; all are cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op1_q <= '0;
      op2_q <= '0;
      sgn_q <= 1'b0;
      acc_q <= '0;
      idx_q <= '0;
      sum_q <= '0;
    end else begin
      op1_q <= op1_d;
      op2_q <= op2_d;
      sgn_q <= sgn_d;
      acc_q <= acc_d;
      idx_q <= idx_d;
      sum_q <= sum_d;
    end
  end

endmodule

// File: tb/tb_red_unit.sv
// Bench for red_unit. It checks the default 16/4 configuration against a
// lane-arithmetic model on every cycle, adds directed literal checks, and runs
// a 32/8 instance with directed vectors.
module tb_red_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Default-configuration instance.
  logic        in_valid, in_ready, sgn, out_valid, out_ready, busy;
  logic [15:0] in1, in2, sum;

  // 32-bit / 8-bit-lane instance.
  logic        p_in_valid, p_in_ready, p_sgn, p_out_valid, p_out_ready, p_busy;
  logic [31:0] p_in1, p_in2, p_sum;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  red_unit u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .In1(in1), .In2(in2), .signed_lanes(sgn), .out_valid(out_valid),
    .out_ready(out_ready), .Sum(sum), .busy(busy)
  );

  red_unit #(.DATA_W(32), .LANE_W(8)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(p_in_valid), .in_ready(p_in_ready),
    .In1(p_in1), .In2(p_in2), .signed_lanes(p_sgn), .out_valid(p_out_valid),
    .out_ready(p_out_ready), .Sum(p_sum), .busy(p_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result: lane values taken as integers, summed, then truncated to dw bits.
  function automatic logic [31:0] model_sum(input logic [31:0] a, input logic [31:0] b,
                                            input bit s, input int dw, input int lw);
    longint total = 0;
    longint lmask = (longint'(1) << lw) - 1;
    longint v;
    for (int i = 0; i < dw / lw; i++) begin
      v = (longint'(a) >> (i * lw)) & lmask;
      if (s && v >= (longint'(1) << (lw - 1))) v -= longint'(1) << lw;
      total += v;
      v = (longint'(b) >> (i * lw)) & lmask;
      if (s && v >= (longint'(1) << (lw - 1))) v -= longint'(1) << lw;
      total += v;
    end
    total = total & ((longint'(1) << dw) - 1);
    return total[31:0];
  endfunction

  // Transaction model: after an accept, the result appears 4 cycles later and is held until taken.
  int          m_cnt;
  logic        m_valid;
  logic [15:0] m_sum, m_pend;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt   <= 0;
      m_valid <= 1'b0;
      m_sum   <= '0;
      m_pend  <= '0;
    end else if (m_valid) begin
      if (out_ready) m_valid <= 1'b0;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_valid <= 1'b1;
        m_sum   <= m_pend;
      end
    end else if (in_valid) begin
      m_cnt  <= 4;
      m_pend <= model_sum({16'h0, in1}, {16'h0, in2}, sgn, 16, 4)[15:0];
    end
  end

  // Compare the DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp in_ready",  {31'h0, in_ready},  {31'h0, (!m_valid && m_cnt == 0)});
      check("cmp out_valid", {31'h0, out_valid}, {31'h0, m_valid});
      check("cmp busy",      {31'h0, busy},      {31'h0, (m_valid || m_cnt != 0)});
      check("cmp sum",       {16'h0, sum},       {16'h0, m_sum});
    end
  end

  // Issue one operation on the 16-bit unit, with out_ready held high, and check latency and result.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input logic [15:0] exp, input string name);
    int cyc;
    check({name, " ready"}, {31'h0, in_ready}, 32'h1);
    in1 = a; in2 = b; sgn = s; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      check({name, " busy"}, {31'h0, busy}, 32'h1);
      @(posedge clk); #1;
      cyc++;
    end
    check({name, " latency"}, cyc, 32'd4);
    check({name, " sum"}, {16'h0, sum}, {16'h0, exp});
    @(posedge clk); #1;
    check({name, " handoff"}, {31'h0, out_valid}, 32'h0);
  endtask

  // Same for the 32-bit unit.
  task automatic run_op32(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [31:0] exp, input string name);
    int cyc;
    p_in1 = a; p_in2 = b; p_sgn = s; p_in_valid = 1'b1;
    @(posedge clk); #1 p_in_valid = 1'b0;
    cyc = 0;
    while (!p_out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, " latency"}, cyc, 32'd4);
    check({name, " sum"}, p_sum, exp);
    @(posedge clk); #1;
    check({name, " in_ready"}, {31'h0, p_in_ready}, 32'h1);
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    in_valid = 1'b0; in1 = '0; in2 = '0; sgn = 1'b0; out_ready = 1'b1;
    p_in_valid = 1'b0; p_in1 = '0; p_in2 = '0; p_sgn = 1'b0; p_out_ready = 1'b1;
    #12;
    check("reset in_ready",  {31'h0, in_ready},  32'h1);
    check("reset out_valid", {31'h0, out_valid}, 32'h0);
    check("reset busy",      {31'h0, busy},      32'h0);
    check("reset sum",       {16'h0, sum},       32'h0);
    rst = 1'b0;
    cmp_en = 1'b1;
    @(posedge clk); #1;

    // Pin the model with hand-computed values.
    check("model unsigned", model_sum(32'h1234, 32'h5678, 1'b0, 16, 4), 32'h0024);
    check("model signed",   model_sum(32'hFFFF, 32'hFFFF, 1'b1, 16, 4), 32'hFFF8);

    run_op(16'h1234, 16'h5678, 1'b0, 16'h0024, "unsigned");
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 16'h0078, "ones unsigned");
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFF8, "ones signed");
    run_op(16'h8888, 16'h8888, 1'b1, 16'hFFC0, "min signed");
    run_op(16'h8888, 16'h8888, 1'b0, 16'h0040, "min unsigned");

    // Backpressure and input isolation. An early out_ready and a second in_valid arrive during ACC.
    out_ready = 1'b0;
    in1 = 16'h1234; in2 = 16'h5678; sgn = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in1 = 16'hFFFF; in2 = 16'hFFFF; sgn = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("bp latency", cyc, 32'd4);
    check("bp sum", {16'h0, sum}, 32'h0024);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp hold sum",       {16'h0, sum},       32'h0024);
      check("bp hold out_valid", {31'h0, out_valid}, 32'h1);
      check("bp hold in_ready",  {31'h0, in_ready},  32'h0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp release out_valid", {31'h0, out_valid}, 32'h0);
    check("bp release in_ready",  {31'h0, in_ready},  32'h1);

    // Reset on ACC cycle 2 clears everything immediately.
    in1 = 16'hFFFF; in2 = 16'hFFFF; sgn = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst out_valid", {31'h0, out_valid}, 32'h0);
    check("midrst sum",       {16'h0, sum},       32'h0);
    check("midrst in_ready",  {31'h0, in_ready},  32'h1);
    check("midrst busy",      {31'h0, busy},      32'h0);
    @(negedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    run_op(16'h0001, 16'h0000, 1'b0, 16'h0001, "after reset");

    // Wider configuration.
    run_op32(32'hFFFFFFFF, 32'h01010101, 1'b0, 32'h00000400, "w32 unsigned");
    run_op32(32'hFFFFFFFF, 32'h01010101, 1'b1, 32'h00000000, "w32 signed");

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/red_unit.md
# red_unit

Parametrised, multi-cycle lane-sum reduction unit for the WISC datapath; successor to the fixed 16-bit RED combinational adder tree. Both operands are split into LANES lanes of LANE_W bits, and one lane pair is accumulated per cycle. Lanes are treated as unsigned or two's-complement per operation. The extended sum is returned through a valid/ready handshake, which lets the EX stage issue RED without a long combinational path.

## Interface
- DATA_W, 16, operand and result width; must be a multiple of LANE_W.
- LANE_W, 4, lane width in bits.
- LANES, DATA_W/LANE_W (derived, not overridable), lane count; must be a power of two and ≥2.
- RES_W, LANE_W+1+clog2(LANES) (derived), internal accumulator width; DATA_W ≥ RES_W is required (elaboration error otherwise).
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and mode are presented.
- in_ready  output  1  unit can accept an operation.
- In1  input  DATA_W  operand 1.
- In2  input  DATA_W  operand 2.
- signed_lanes  input  1  1 = lanes are two's complement, 0 = unsigned.
- out_valid  output  1  Sum holds a completed result.
- out_ready  input  1  consumer takes the result.
- Sum  output  DATA_W  reduction result, sign- or zero-extended from RES_W.
- busy  output  1  high in ACC or DONE.

## Operation
- Result is Σ(i=0..LANES-1) of (In1 lane i + In2 lane i), where lane i = bits [i*LANE_W+LANE_W-1 : i*LANE_W].
- Each lane is extended to RES_W before it is added. Extension is sign extension if signed_lanes = 1, zero extension otherwise. RES_W is chosen so that overflow is impossible.
- Sum = accumulator extended to DATA_W, using sign extension if the captured signed_lanes = 1 and zero extension otherwise.
- FSM states:
  - IDLE: in_ready = 1.
    - On in_valid: capture In1, In2 and signed_lanes; clear the accumulator; set lane index = 0; go to ACC.
  - ACC: on each edge, accumulator += ext(In1 lane idx) + ext(In2 lane idx) and idx++.
    - On the edge that adds lane LANES-1: load the Sum register and go to DONE.
  - DONE: out_valid = 1.
    - On out_ready: go to IDLE.
    - Otherwise hold Sum, out_valid and state indefinitely.
- in_ready is high only in IDLE. in_valid outside IDLE is ignored; operands are not latched.
- Input changes after the accept edge have no effect, because operands and mode are captured at accept.
- Sum changes only on entry to DONE. It holds its last value through IDLE and ACC, until the next completion.
- Index counter: clog2(LANES) bits, wraps to 0 at completion.

## Timing
- Reset values (asynchronous, immediate on rst rising):
  - state = IDLE, in_ready = 1, out_valid = 0, busy = 0.
  - Sum = 0, accumulator = 0, index = 0.
  - Any in-flight operation is discarded.
- Accept edge is T0 (in_valid && in_ready). ACC adds occur on edges T1..T_LANES. out_valid rises after edge T_LANES.
- Default configuration: out_valid is visible 4 cycles after the accept edge.
- Handshake completes on the first edge with out_valid && out_ready. in_ready is high from the following cycle, so a back-to-back op can be accepted one cycle after result handoff.
- Minimum issue interval: LANES+2 cycles.
- out_ready asserted before out_valid has no effect and is not remembered.
- rst asserted during ACC or DONE clears everything. Operation restarts only on a new accept after rst deasserts.

## Test plan
- Unsigned, default params: In1 = 16'h1234, In2 = 16'h5678, signed_lanes = 0, out_ready = 1 → out_valid exactly 4 cycles after accept, Sum = 16'h0024, busy high for the intervening cycles.
- Extremes: In1 = In2 = 16'hFFFF.
  - signed_lanes = 0 → Sum = 16'h0078.
  - signed_lanes = 1 → Sum = 16'hFFF8.
- Signed minimum: In1 = In2 = 16'h8888.
  - signed_lanes = 1 → Sum = 16'hFFC0.
  - signed_lanes = 0 → Sum = 16'h0040.
- Backpressure and input isolation:
  - Hold out_ready = 0 for 5 cycles after out_valid → Sum, out_valid stable, in_ready = 0.
  - During ACC, change In1/In2 and pulse in_valid → no effect on the result.
  - Raise out_ready → IDLE on the next edge.
- Reset mid-operation: assert rst on ACC cycle 2 → out_valid = 0, Sum = 0 and in_ready = 1 immediately. A subsequent op with In1 = 16'h0001, In2 = 16'h0000 returns Sum = 16'h0001.
- Parametrisation: DATA_W = 32, LANE_W = 8, In1 = 32'hFFFFFFFF, In2 = 32'h01010101, unsigned → Sum = 32'h00000400 after 4 cycles. The same stimulus signed → Sum = 32'h00000000.
